muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 46 ++++
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Purpose: shared op encodings (ALU + multiply/divide) and the muldiv FSM state type.
// Latency: n/a (types and helper functions only).
// Backpressure: n/a.
// Ports: none.
package muldiv_pkg;

  // The ALU occupies codes 0..10, so the muldiv codes start right above it
  // and the two decoders can share one 4-bit op bus without overlap.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_LUI  = 4'b1010
  } alu_op_e;

  typedef enum logic [3:0] {
    OP_MUL  = 4'b1011,
    OP_MULH = 4'b1100,
    OP_DIV  = 4'b1101,
    OP_REM  = 4'b1110,
    OP_DIVU = 4'b1111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVU);
  endfunction

  // Everything except DIVU works on magnitudes with a final sign fix.
  function automatic logic is_signed_op(input logic [3:0] op);
    return (op != OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Purpose: one combinational iteration: shift-add (multiply) or restoring shift-subtract (divide).
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
// Ports: is_div selects the divide step; hi_i/lo_i are the accumulator halves,
//        b_i the multiplicand/divisor magnitude; hi_o/lo_o the updated halves.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic           ge;

  always_comb begin
    // Multiply: {hi,lo} holds partial product over the remaining multiplier bits.
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    // Divide: hi is the partial remainder, lo feeds dividend bits in MSB-first
    // and collects quotient bits at the bottom.
    shifted = {hi_i, lo_i[WIDTH-1]};
    ge      = (shifted >= {1'b0, b_i});

    hi_o = sum[WIDTH:1];
    lo_o = {sum[0], lo_i[WIDTH-1:1]};
    if (is_div) begin
      if (ge) begin
        // True difference is < b_i, so the modulo-2^WIDTH subtract is exact.
        hi_o = shifted[WIDTH-1:0] - b_i;
        lo_o = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        hi_o = shifted[WIDTH-1:0];
        lo_o = {lo_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Purpose: iterative multiply/divide unit (MUL, MULH, DIV, REM, DIVU) behind a valid/ready handshake.
// Latency: out_valid rises exactly WIDTH cycles after acceptance, regardless of operands.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; flush aborts.
// Ports: clk/rst_n (sync, active-low), flush; in_valid/in_ready/op/A/B request side;
//        out_valid/out_ready/result response side.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  muldiv_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               neg_q, neg_d, neg_rem_q, neg_rem_d;

  logic               op_is_div;
  logic [WIDTH-1:0]   step_hi, step_lo;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fix_quo, fix_rem;

  assign op_is_div = is_div_op(op_q);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (op_is_div),
    .hi_i   (hi_q),
    .lo_i   (lo_q),
    .b_i    (b_q),
    .hi_o   (step_hi),
    .lo_o   (step_lo)
  );

  // Operand magnitudes. The most-negative value maps to 2^(WIDTH-1), which
  // still fits unsigned, so DIV overflow falls out as quotient 2^(WIDTH-1)
  // with no sign flip (== A) and remainder 0 without special casing.
  always_comb begin
    sgn_a = is_signed_op(op) && A[WIDTH-1];
    sgn_b = is_signed_op(op) && B[WIDTH-1];
    mag_a = sgn_a ? -A : A;
    mag_b = sgn_b ? -B : B;
  end

  // Sign fix on the values the last iteration produces.
  always_comb begin
    prod = {step_hi, step_lo};
    if (neg_q) prod = -prod;
    fix_quo = neg_q     ? -step_lo : step_lo;
    fix_rem = neg_rem_q ? -step_hi : step_hi;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    b_d       = b_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d   = ST_BUSY;
            cnt_d     = '0;
            op_d      = op;
            hi_d      = '0;
            lo_d      = mag_a;
            b_d       = mag_b;
            // Divide by zero keeps the all-ones raw quotient un-negated; the
            // raw remainder is |A|, which the dividend sign turns back into A.
            neg_d     = (sgn_a ^ sgn_b) && (B != '0);
            neg_rem_d = sgn_a;
          end
        end
        ST_BUSY: begin
          hi_d  = step_hi;
          lo_d  = step_lo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = ST_DONE;
            case (op_q)
              OP_MUL:          result_d = prod[WIDTH-1:0];
              OP_MULH:         result_d = prod[2*WIDTH-1:WIDTH];
              OP_DIV, OP_DIVU: result_d = fix_quo;
              OP_REM:          result_d = fix_rem;
              default:         result_d = '0;
            endcase
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Purpose: directed + small random checks of muldiv_unit with an expected-result queue.
// Latency: checks out_valid arrives exactly WIDTH cycles after acceptance.
// Backpressure: exercises out_ready stall, flush mid-operation and reset in DONE.
module tb_muldiv_unit;

  localparam int W = 32;
  localparam logic [3:0] MUL  = 4'b1011;
  localparam logic [3:0] MULH = 4'b1100;
  localparam logic [3:0] DIV  = 4'b1101;
  localparam logic [3:0] REM  = 4'b1110;
  localparam logic [3:0] DIVU = 4'b1111;

  logic         clk = 1'b0;
  logic         rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] A, B, result;

  int           vectors = 0;
  int           miscompares = 0;
  int           seen;
  logic [W-1:0] exp_q[$];
  logic [3:0]   ro;
  logic [W-1:0] ra, rb;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference built on native SV arithmetic plus the special-case rules.
  function automatic logic [W-1:0] model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0]   sa, sb, q;
    logic signed [2*W-1:0] xa, xb, p;
    logic                  ovf;
    sa  = a;
    sb  = b;
    xa  = sa;
    xb  = sb;
    p   = xa * xb;
    ovf = (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
    case (o)
      MUL:  return p[W-1:0];
      MULH: return p[2*W-1:W];
      DIV: begin
        if (b == '0) return '1;
        if (ovf) return a;
        q = sa / sb;
        return q;
      end
      REM: begin
        if (b == '0) return a;
        if (ovf) return '0;
        q = sa % sb;
        return q;
      end
      DIVU: begin
        if (b == '0) return '1;
        return a / b;
      end
      default: return '0;
    endcase
  endfunction

  // Called about 1ns after a rising edge with the unit idle.
  task automatic start_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e, input bit push);
    check({tag, " in_ready"}, W'(in_ready), W'(1));
    op = o; A = a; B = b; in_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, W'(lat), W'(W));
  endtask

  task automatic take_result(input string tag);
    logic [W-1:0] e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check({tag, " result"}, result, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " out_valid drop"}, W'(out_valid), '0);
    check({tag, " in_ready back"}, W'(in_ready), W'(1));
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] e);
    start_op(tag, o, a, b, e, 1'b1);
    wait_done(tag);
    take_result(tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", W'(in_ready), W'(1));
    check("reset out_valid", W'(out_valid), '0);
    check("reset result", result, '0);
    rst_n = 1'b1;

    // First request lands on the first edge after reset release.
    run_op("mul 7x6", MUL, 32'd7, 32'd6, 32'd42);
    run_op("mulh -1x-1", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulh min x2", MULH, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF);
    run_op("mul -3x5", MUL, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_op("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_op("divu big/2", DIVU, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF);
    run_op("div 5/0", DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("rem 5/0", REM, 32'd5, 32'd0, 32'd5);
    run_op("divu 9/0", DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("bad op", 4'b0010, 32'd123, 32'd45, 32'h0000_0000);

    for (int i = 0; i < 8; i++) begin
      ro = (i == 7) ? 4'($urandom_range(0, 10)) : 4'($urandom_range(11, 15));
      ra = $urandom;
      rb = $urandom;
      if (i % 3 == 0) rb = rb >> 20;
      run_op("random", ro, ra, rb, model(ro, ra, rb));
    end

    // Consumer stalls for 10 cycles in DONE.
    start_op("stall", MUL, 32'd3, 32'd4, 32'd12, 1'b1);
    wait_done("stall");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("stall result", result, exp_q[0]);
      check("stall out_valid", W'(out_valid), W'(1));
      check("stall in_ready", W'(in_ready), '0);
    end
    take_result("stall");

    // Flush on cycle 15 of BUSY, with a competing request that must be ignored.
    start_op("flush", DIV, 32'd100, 32'd7, '0, 1'b0);
    repeat (14) begin
      @(posedge clk); #1;
    end
    flush = 1'b1; in_valid = 1'b1; op = MUL; A = 32'd2; B = 32'd2;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush in_ready", W'(in_ready), W'(1));
    check("flush out_valid", W'(out_valid), '0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("flush no output", W'(seen), '0);
    run_op("after flush", REM, 32'd100, 32'd7, 32'd2);

    // Reset while a result waits in DONE.
    start_op("rst done", MUL, 32'd9, 32'd9, '0, 1'b0);
    wait_done("rst done");
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst done in_ready", W'(in_ready), W'(1));
    check("rst done out_valid", W'(out_valid), '0);
    check("rst done result", result, '0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst no output", W'(seen), '0);
    run_op("after rst", DIVU, 32'd1000, 32'd10, 32'd100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
